// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline: ALU encodings, forward selects, ID/EX register layout.
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [2:0]        alu_op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  // A later stage supplies a value for idx; register 0 is hardwired and never matches.
  function automatic logic fwd_hit(input logic we, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] idx);
    return we && (rd != '0) && (rd == idx);
  endfunction

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding select for one ALU source; EX/MEM has priority over MEM/WB.
module forward_mux
  import mips_pkg::*;
(
  input  logic [REG_W-1:0]  reg_idx_i,
  input  logic              ex_mem_we_i,
  input  logic [REG_W-1:0]  ex_mem_rd_i,
  input  logic [DATA_W-1:0] ex_mem_data_i,
  input  logic              mem_wb_we_i,
  input  logic [REG_W-1:0]  mem_wb_rd_i,
  input  logic [DATA_W-1:0] mem_wb_data_i,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] data_o,
  output fwd_sel_e          sel_o
);

  always_comb begin
    // NOTE: default assigned first so every path drives the output; no latch is inferred.
    sel_o = FWD_REG;
    if (fwd_hit(ex_mem_we_i, ex_mem_rd_i, reg_idx_i))
      sel_o = FWD_EXMEM;
    else if (fwd_hit(mem_wb_we_i, mem_wb_rd_i, reg_idx_i))
      sel_o = FWD_MEMWB;
  end

  always_comb begin
    data_o = reg_data_i;
    case (sel_o)
      FWD_EXMEM: data_o = ex_mem_data_i;
      FWD_MEMWB: data_o = mem_wb_data_i;
      default:   data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, load-use detection and bubble insertion.
// Optional hazard counters are enabled with `define ID_EX_HAZARD_STATS_EN.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              idValid,
  input  logic [DATA_W-1:0] idRsData,
  input  logic [DATA_W-1:0] idRtData,
  input  logic [DATA_W-1:0] idImm,
  input  logic [REG_W-1:0]  idRs,
  input  logic [REG_W-1:0]  idRt,
  input  logic [REG_W-1:0]  idRd,
  input  logic [2:0]        idAluOp,
  input  logic              idAluSrc,
  input  logic              idRegDst,
  input  logic              idRegWrite,
  input  logic              idMemRead,
  input  logic              idMemWrite,
  input  logic              idMemToReg,
  input  logic              flush,
  input  logic              exMemRegWrite,
  input  logic [REG_W-1:0]  exMemRd,
  input  logic [DATA_W-1:0] exMemAluOut,
  input  logic              memWbRegWrite,
  input  logic [REG_W-1:0]  memWbRd,
  input  logic [DATA_W-1:0] memWbData,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [2:0]        aluOp,
  output logic [DATA_W-1:0] exStoreData,
  output logic [REG_W-1:0]  exDst,
  output logic              exValid,
  output logic              exRegWrite,
  output logic              exMemRead,
  output logic              exMemWrite,
  output logic              exMemToReg,
  output logic              loadUseStall
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [31:0]       stallCount,
  output logic [31:0]       flushCount
`endif
);

  id_ex_t            ex_q, ex_d;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  fwd_sel_e          fwd_a_sel_unused, fwd_b_sel_unused;

  assign loadUseStall = ex_q.valid & ex_q.mem_read & (ex_q.dst != '0) & idValid &
                        ((ex_q.dst == idRs) | (ex_q.dst == idRt));

  always_comb begin
    ex_d = ex_q;
    if (flush || loadUseStall) begin
      // Bubble: only controls are cleared, data fields may go stale.
      ex_d.valid      = 1'b0;
      ex_d.reg_write  = 1'b0;
      ex_d.mem_read   = 1'b0;
      ex_d.mem_write  = 1'b0;
      ex_d.mem_to_reg = 1'b0;
    end else begin
      ex_d.valid      = idValid;
      ex_d.reg_write  = idRegWrite;
      ex_d.mem_read   = idMemRead;
      ex_d.mem_write  = idMemWrite;
      ex_d.mem_to_reg = idMemToReg;
      ex_d.alu_src    = idAluSrc;
      ex_d.alu_op     = idAluOp;
      ex_d.rs         = idRs;
      ex_d.rt         = idRt;
      ex_d.dst        = idRegDst ? idRd : idRt;
      ex_d.imm        = idImm;
      ex_d.rs_data    = fwd_hit(memWbRegWrite, memWbRd, idRs) ? memWbData : idRsData;
      ex_d.rt_data    = fwd_hit(memWbRegWrite, memWbRd, idRt) ? memWbData : idRtData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  forward_mux u_fwd_a (
    .reg_idx_i     (ex_q.rs),
    .ex_mem_we_i   (exMemRegWrite),
    .ex_mem_rd_i   (exMemRd),
    .ex_mem_data_i (exMemAluOut),
    .mem_wb_we_i   (memWbRegWrite),
    .mem_wb_rd_i   (memWbRd),
    .mem_wb_data_i (memWbData),
    .reg_data_i    (ex_q.rs_data),
    .data_o        (fwd_a),
    .sel_o         (fwd_a_sel_unused)
  );

  forward_mux u_fwd_b (
    .reg_idx_i     (ex_q.rt),
    .ex_mem_we_i   (exMemRegWrite),
    .ex_mem_rd_i   (exMemRd),
    .ex_mem_data_i (exMemAluOut),
    .mem_wb_we_i   (memWbRegWrite),
    .mem_wb_rd_i   (memWbRd),
    .mem_wb_data_i (memWbData),
    .reg_data_i    (ex_q.rt_data),
    .data_o        (fwd_b),
    .sel_o         (fwd_b_sel_unused)
  );

  assign op1         = fwd_a;
  assign op2         = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign exStoreData = fwd_b;
  assign aluOp       = ex_q.alu_op;
  assign exDst       = ex_q.dst;
  assign exValid     = ex_q.valid;
  assign exRegWrite  = ex_q.reg_write;
  assign exMemRead   = ex_q.mem_read;
  assign exMemWrite  = ex_q.mem_write;
  assign exMemToReg  = ex_q.mem_to_reg;

`ifdef ID_EX_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // A flush bubble takes precedence, so a simultaneous stall is counted as a flush only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (flush) begin
      if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end else if (loadUseStall) begin
      if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table with scoreboard plus hazard/reset sequences.
module tb_id_ex_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [2:0]  alu_op;
    logic        alu_src, reg_dst;
    logic [3:0]  ctrl;       // {regWrite, memRead, memWrite, memToReg}
  } id_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } src_t;

  typedef struct packed {
    logic [31:0] op1, op2, store;
    logic [2:0]  alu;
    logic [4:0]  dst;
    logic        valid;
    logic [3:0]  ctrl;
  } out_t;

  typedef struct packed {
    id_t  id;
    src_t cap_wb;   // MEM/WB source present at capture (bypass)
    src_t em;       // EX/MEM source while the instruction sits in EX
    src_t mw;       // MEM/WB source while the instruction sits in EX
    out_t exp;
  } vec_t;

  localparam src_t NO = '{1'b0, 5'd0, 32'd0};
  localparam id_t  IDLE = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 4'd0};

  logic        clk = 1'b0;
  logic        reset;
  logic        idValid;
  logic [31:0] idRsData, idRtData, idImm;
  logic [4:0]  idRs, idRt, idRd;
  logic [2:0]  idAluOp;
  logic        idAluSrc, idRegDst, idRegWrite, idMemRead, idMemWrite, idMemToReg;
  logic        flush;
  logic        exMemRegWrite, memWbRegWrite;
  logic [4:0]  exMemRd, memWbRd;
  logic [31:0] exMemAluOut, memWbData;
  logic [31:0] op1, op2, exStoreData;
  logic [2:0]  aluOp;
  logic [4:0]  exDst;
  logic        exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, loadUseStall;
`ifdef ID_EX_HAZARD_STATS_EN
  logic [31:0] stallCount, flushCount;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .idValid(idValid),
    .idRsData(idRsData), .idRtData(idRtData), .idImm(idImm),
    .idRs(idRs), .idRt(idRt), .idRd(idRd), .idAluOp(idAluOp),
    .idAluSrc(idAluSrc), .idRegDst(idRegDst), .idRegWrite(idRegWrite),
    .idMemRead(idMemRead), .idMemWrite(idMemWrite), .idMemToReg(idMemToReg),
    .flush(flush),
    .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemAluOut(exMemAluOut),
    .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbData(memWbData),
    .op1(op1), .op2(op2), .aluOp(aluOp), .exStoreData(exStoreData), .exDst(exDst),
    .exValid(exValid), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exMemToReg(exMemToReg), .loadUseStall(loadUseStall)
`ifdef ID_EX_HAZARD_STATS_EN
    , .stallCount(stallCount), .flushCount(flushCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_id(input id_t x);
    idValid  = x.valid;   idRs = x.rs;  idRt = x.rt;  idRd = x.rd;
    idRsData = x.rs_data; idRtData = x.rt_data; idImm = x.imm;
    idAluOp  = x.alu_op;  idAluSrc = x.alu_src; idRegDst = x.reg_dst;
    {idRegWrite, idMemRead, idMemWrite, idMemToReg} = x.ctrl;
  endtask

  task automatic drive_src(input src_t em, input src_t mw);
    exMemRegWrite = em.we; exMemRd = em.rd; exMemAluOut = em.data;
    memWbRegWrite = mw.we; memWbRd = mw.rd; memWbData = mw.data;
  endtask

  function automatic out_t sample();
    return '{op1, op2, exStoreData, aluOp, exDst, exValid,
             {exRegWrite, exMemRead, exMemWrite, exMemToReg}};
  endfunction

  task automatic check_out(input string tag, input out_t exp);
    out_t act;
    act = sample();
    check({tag, ".op1"},   act.op1,   exp.op1);
    check({tag, ".op2"},   act.op2,   exp.op2);
    check({tag, ".store"}, act.store, exp.store);
    check({tag, ".misc"},  {19'd0, act.alu, act.dst, act.valid, act.ctrl},
                           {19'd0, exp.alu, exp.dst, exp.valid, exp.ctrl});
  endtask

  vec_t vecs[11];
  out_t sb[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    id_t  lw, dep, add1;
    out_t got, want;
`ifdef ID_EX_HAZARD_STATS_EN
    logic [31:0] s0, f0;
`endif

    vecs[0]  = '{'{1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd0, ALU_ADD, 1'b0, 1'b1, 4'b1000},
                 NO, NO, NO, '{32'd10, 32'd20, 32'd20, ALU_ADD, 5'd3, 1'b1, 4'b1000}};
    vecs[1]  = '{'{1'b1, 5'd4, 5'd5, 5'd0, 32'h100, 32'h55, 32'hFFFF_FFFC, ALU_ADD, 1'b1, 1'b0, 4'b1000},
                 NO, NO, NO, '{32'h100, 32'hFFFF_FFFC, 32'h55, ALU_ADD, 5'd5, 1'b1, 4'b1000}};
    vecs[2]  = '{'{1'b1, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'd0, ALU_SUB, 1'b0, 1'b1, 4'b1000},
                 NO, '{1'b1, 5'd5, 32'h11}, '{1'b1, 5'd5, 32'h22},
                 '{32'h11, 32'hB, 32'hB, ALU_SUB, 5'd7, 1'b1, 4'b1000}};
    vecs[3]  = '{'{1'b1, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'd0, ALU_SUB, 1'b0, 1'b1, 4'b1000},
                 NO, '{1'b0, 5'd5, 32'h11}, '{1'b1, 5'd5, 32'h22},
                 '{32'h22, 32'hB, 32'hB, ALU_SUB, 5'd7, 1'b1, 4'b1000}};
    vecs[4]  = '{'{1'b1, 5'd0, 5'd9, 5'd0, 32'd0, 32'd9, 32'd0, ALU_OR, 1'b0, 1'b0, 4'b1000},
                 NO, '{1'b1, 5'd0, 32'hFF}, '{1'b1, 5'd0, 32'hEE},
                 '{32'd0, 32'd9, 32'd9, ALU_OR, 5'd9, 1'b1, 4'b1000}};
    vecs[5]  = '{'{1'b1, 5'd2, 5'd3, 5'd0, 32'h40, 32'h1, 32'd8, ALU_ADD, 1'b1, 1'b0, 4'b0010},
                 '{1'b1, 5'd3, 32'h77}, NO, NO,
                 '{32'h40, 32'd8, 32'h77, ALU_ADD, 5'd3, 1'b1, 4'b0010}};
    vecs[6]  = '{'{1'b1, 5'd12, 5'd13, 5'd14, 32'd1, 32'd2, 32'd0, ALU_SLT, 1'b0, 1'b1, 4'b1000},
                 NO, '{1'b1, 5'd12, 32'hAAAA}, '{1'b1, 5'd13, 32'hBBBB},
                 '{32'hAAAA, 32'hBBBB, 32'hBBBB, ALU_SLT, 5'd14, 1'b1, 4'b1000}};
    vecs[7]  = '{'{1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0, ALU_AND, 1'b0, 1'b1, 4'b1000},
                 NO, NO, NO, '{32'd5, 32'd6, 32'd6, ALU_AND, 5'd3, 1'b0, 4'b1000}};
    vecs[8]  = '{'{1'b1, 5'd31, 5'd0, 5'd0, 32'h123, 32'd3, 32'd0, ALU_ADD, 1'b0, 1'b0, 4'b1000},
                 '{1'b1, 5'd0, 32'h99}, NO, NO,
                 '{32'h123, 32'd3, 32'd3, ALU_ADD, 5'd0, 1'b1, 4'b1000}};
    vecs[9]  = '{'{1'b1, 5'd7, 5'd8, 5'd9, 32'h66, 32'h88, 32'd0, ALU_SUB, 1'b0, 1'b1, 4'b1000},
                 '{1'b0, 5'd7, 32'h55}, NO, NO,
                 '{32'h66, 32'h88, 32'h88, ALU_SUB, 5'd9, 1'b1, 4'b1000}};
    vecs[10] = '{'{1'b1, 5'd6, 5'd1, 5'd2, 32'h5, 32'h30, 32'd0, ALU_OR, 1'b0, 1'b1, 4'b1000},
                 '{1'b1, 5'd6, 32'h10}, '{1'b1, 5'd6, 32'h20}, NO,
                 '{32'h20, 32'h30, 32'h30, ALU_OR, 5'd2, 1'b1, 4'b1000}};

    // Reset state
    reset = 1'b1; flush = 1'b0;
    drive_id(IDLE); drive_src(NO, NO);
    #12;
    check_out("reset", '0);
    check("reset.stall", 32'(loadUseStall), 32'd0);
`ifdef ID_EX_HAZARD_STATS_EN
    check("reset.stallCount", stallCount, 32'd0);
    check("reset.flushCount", flushCount, 32'd0);
`endif
    @(posedge clk); #1 reset = 1'b0;

    // Table: capture one vector per cycle, check it while it sits in EX
    foreach (vecs[i]) begin
      drive_id(vecs[i].id);
      drive_src(NO, vecs[i].cap_wb);
      sb.push_back(vecs[i].exp);
      @(posedge clk); #1;
      drive_id(IDLE);
      drive_src(vecs[i].em, vecs[i].mw);
      #1;
      if (sb.size() == 0) begin
        check($sformatf("vec%0d.sb_empty", i), 32'd1, 32'd0);
      end else begin
        want = sb.pop_front();
        check_out($sformatf("vec%0d", i), want);
      end
    end
    drive_src(NO, NO);

    // Load-use: lw r8 in EX, dependent add in ID
    lw   = '{1'b1, 5'd1, 5'd8, 5'd0, 32'h4, 32'h0, 32'd0, ALU_ADD, 1'b1, 1'b0, 4'b1101};
    dep  = '{1'b1, 5'd8, 5'd2, 5'd4, 32'h1234, 32'h2, 32'd0, ALU_ADD, 1'b0, 1'b1, 4'b1000};
    add1 = '{1'b1, 5'd10, 5'd11, 5'd12, 32'h50, 32'h60, 32'd0, ALU_ADD, 1'b0, 1'b1, 4'b1000};
`ifdef ID_EX_HAZARD_STATS_EN
    s0 = stallCount; f0 = flushCount;
`endif
    drive_id(lw);
    @(posedge clk); #1 drive_id(dep); #1;
    check("lu.stall_hi", 32'(loadUseStall), 32'd1);
    @(posedge clk); #1;
    got = sample();
    check("lu.bubble_valid", 32'(got.valid), 32'd0);
    check("lu.bubble_ctrl", 32'(got.ctrl), 32'd0);
    check("lu.stall_released", 32'(loadUseStall), 32'd0);
    @(posedge clk); #1 drive_id(IDLE); #1;
    got = sample();
    check("lu.dep_valid", 32'(got.valid), 32'd1);
    check("lu.dep_dst", 32'(got.dst), 32'd4);
    check("lu.dep_op1", got.op1, 32'h1234);
`ifdef ID_EX_HAZARD_STATS_EN
    check("lu.stallCount", stallCount, s0 + 32'd1);
    check("lu.flushCount", flushCount, f0);
`endif

    // Flush together with load-use: flush wins, stall output still high
    @(posedge clk); #1 drive_id(lw);
    @(posedge clk); #1 drive_id(dep); flush = 1'b1; #1;
    check("fs.stall_hi", 32'(loadUseStall), 32'd1);
`ifdef ID_EX_HAZARD_STATS_EN
    s0 = stallCount; f0 = flushCount;
`endif
    @(posedge clk); #1 flush = 1'b0; drive_id(IDLE); #1;
    got = sample();
    check("fs.bubble_valid", 32'(got.valid), 32'd0);
    check("fs.bubble_ctrl", 32'(got.ctrl), 32'd0);
`ifdef ID_EX_HAZARD_STATS_EN
    check("fs.flushCount", flushCount, f0 + 32'd1);
    check("fs.stallCount", stallCount, s0);
`endif

    // Flush alone squashes a valid instruction
    drive_id(add1); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; drive_id(IDLE); #1;
    got = sample();
    check("fl.valid", 32'(got.valid), 32'd0);
    check("fl.ctrl", 32'(got.ctrl), 32'd0);

    // Asynchronous reset mid-stream
    drive_id(add1);
    @(posedge clk); #1;
    check("rs.pre_valid", 32'(exValid), 32'd1);
    #2 reset = 1'b1; #1;
    check_out("rs.async", '0);
`ifdef ID_EX_HAZARD_STATS_EN
    check("rs.stallCount", stallCount, 32'd0);
    check("rs.flushCount", flushCount, 32'd0);
`endif
    @(posedge clk); #1 reset = 1'b0; #1;
    check("rs.no_capture_yet", 32'(exValid), 32'd0);
    @(posedge clk); #1;
    check("rs.first_capture_valid", 32'(exValid), 32'd1);
    check("rs.first_capture_op1", op1, 32'h50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
